// File: rtl/cnn_layer_accel_macc_array.sv
// Multi-lane MACC engine: shared weight times NUM_LANES activations, accumulated
// over a run-time group length, then biased, rounded, shifted and saturated per lane.
`timescale 1ns/1ps
module cnn_layer_accel_macc_array #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned A_WIDTH    = 16,
    parameter int unsigned B_WIDTH    = 16,
    parameter int unsigned ACC_WIDTH  = 48,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FRAC_SHIFT = 8,
    parameter int unsigned LEN_WIDTH  = 10
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic [LEN_WIDTH-1:0]           cfg_len,
    input  logic                           cfg_bias_en,
    input  logic [NUM_LANES*ACC_WIDTH-1:0] bias,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]             in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*OUT_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]           out_sat,
    output logic                           busy
);

    localparam int unsigned PROD_WIDTH = A_WIDTH + B_WIDTH;
    localparam int unsigned RND_WIDTH  = ACC_WIDTH + 1;
    localparam int unsigned RND_POS    = (FRAC_SHIFT == 0) ? 0 : FRAC_SHIFT - 1;
    localparam logic signed [RND_WIDTH-1:0] RND_ADD =
        (FRAC_SHIFT == 0) ? '0 : (RND_WIDTH'(1) << RND_POS);
    localparam logic signed [RND_WIDTH-1:0] OUT_MAX =
        {{(RND_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RND_WIDTH-1:0] OUT_MIN =
        {{(RND_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;

    logic                        s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic signed [A_WIDTH-1:0]   s1_a_q    [NUM_LANES];
    logic signed [A_WIDTH-1:0]   s1_a_d    [NUM_LANES];
    logic signed [B_WIDTH-1:0]   s1_b_q, s1_b_d;
    logic signed [ACC_WIDTH-1:0] s1_bias_q [NUM_LANES];
    logic signed [ACC_WIDTH-1:0] s1_bias_d [NUM_LANES];

    logic                        s2_v_q, s2_v_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
    logic signed [ACC_WIDTH-1:0] s2_m_q    [NUM_LANES];
    logic signed [ACC_WIDTH-1:0] s2_m_d    [NUM_LANES];
    logic signed [ACC_WIDTH-1:0] s2_bias_q [NUM_LANES];
    logic signed [ACC_WIDTH-1:0] s2_bias_d [NUM_LANES];

    logic                        s3_v_q, s3_v_d, s3_last_q, s3_last_d;
    logic signed [ACC_WIDTH-1:0] acc_q     [NUM_LANES];
    logic signed [ACC_WIDTH-1:0] acc_d     [NUM_LANES];

    logic                           out_valid_q, out_valid_d;
    logic [NUM_LANES*OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_LANES-1:0]           out_sat_q, out_sat_d;

    logic                           stall, accept, first, last;
    logic [LEN_WIDTH-1:0]           len_eff, cur_len;
    logic signed [PROD_WIDTH-1:0]   prod   [NUM_LANES];
    logic signed [RND_WIDTH-1:0]    q_sum  [NUM_LANES];
    logic signed [RND_WIDTH-1:0]    q_shr  [NUM_LANES];
    logic [NUM_LANES*OUT_WIDTH-1:0] q_data;
    logic [NUM_LANES-1:0]           q_sat;

    // Global clock enable: everything holds while a result waits for the consumer.
    assign stall   = out_valid_q && !out_ready;
    assign accept  = in_valid && !stall;
    assign first   = (cnt_q == '0);
    assign len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    assign cur_len = first ? len_eff : len_q;
    assign last    = (cnt_q == cur_len - LEN_WIDTH'(1));

    // Per-lane product and output quantisation (round half up, shift, clamp).
    always_comb begin
        q_data = '0;
        q_sat  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            prod[l]  = PROD_WIDTH'(s1_a_q[l]) * PROD_WIDTH'(s1_b_q);
            q_sum[l] = RND_WIDTH'(acc_q[l]) + RND_ADD;
            q_shr[l] = q_sum[l] >>> FRAC_SHIFT;
            if (q_shr[l] > OUT_MAX) begin
                q_data[l*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
                q_sat[l] = 1'b1;
            end else if (q_shr[l] < OUT_MIN) begin
                q_data[l*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
                q_sat[l] = 1'b1;
            end else begin
                q_data[l*OUT_WIDTH +: OUT_WIDTH] = q_shr[l][OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        s1_v_d      = s1_v_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_bias_d   = s1_bias_q;
        s2_v_d      = s2_v_q;
        s2_first_d  = s2_first_q;
        s2_last_d   = s2_last_q;
        s2_m_d      = s2_m_q;
        s2_bias_d   = s2_bias_q;
        s3_v_d      = s3_v_q;
        s3_last_d   = s3_last_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (!stall) begin
            s1_v_d = accept;
            if (accept) begin
                cnt_d      = last ? '0 : cnt_q + LEN_WIDTH'(1);
                s1_first_d = first;
                s1_last_d  = last;
                s1_b_d     = in_b;
                if (first) len_d = len_eff;
                for (int l = 0; l < NUM_LANES; l++) begin
                    s1_a_d[l] = in_a[l*A_WIDTH +: A_WIDTH];
                    if (first) s1_bias_d[l] = cfg_bias_en ? bias[l*ACC_WIDTH +: ACC_WIDTH] : '0;
                end
            end

            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_first_d = s1_first_q;
                s2_last_d  = s1_last_q;
                for (int l = 0; l < NUM_LANES; l++) begin
                    s2_m_d[l]    = ACC_WIDTH'(prod[l]);
                    s2_bias_d[l] = s1_bias_q[l];
                end
            end

            // A first beat restarts the accumulator, so groups need no idle gap.
            s3_v_d    = s2_v_q;
            s3_last_d = s2_last_q;
            if (s2_v_q) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    acc_d[l] = s2_first_q ? s2_m_q[l] + s2_bias_q[l] : acc_q[l] + s2_m_q[l];
                end
            end

            out_valid_d = s3_v_q && s3_last_q;
            if (s3_v_q && s3_last_q) begin
                out_data_d = q_data;
                out_sat_d  = q_sat;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            s1_v_q      <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_b_q      <= '0;
            s2_v_q      <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_v_q      <= 1'b0;
            s3_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                s1_a_q[l]    <= '0;
                s1_bias_q[l] <= '0;
                s2_m_q[l]    <= '0;
                s2_bias_q[l] <= '0;
                acc_q[l]     <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            s1_v_q      <= s1_v_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_bias_q   <= s1_bias_d;
            s2_v_q      <= s2_v_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            s2_m_q      <= s2_m_d;
            s2_bias_q   <= s2_bias_d;
            s3_v_q      <= s3_v_d;
            s3_last_q   <= s3_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = (cnt_q != '0) || s1_v_q || s2_v_q || s3_v_q || out_valid_q;

endmodule

// File: tb/tb_cnn_layer_accel_macc_array.sv
// Directed bench for cnn_layer_accel_macc_array: hand-computed results checked in order by a
// negedge monitor, plus latency, backpressure, streaming and reset checks.
`timescale 1ns/1ps
module tb_cnn_layer_accel_macc_array;

    logic         CLK = 1'b0;
    logic         rst;
    logic [9:0]   cfg_len;
    logic         cfg_bias_en;
    logic [191:0] bias;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_a;
    logic [15:0]  in_b;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [3:0]   out_sat;
    logic         busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [67:0] exp_q[$];
    int          run_len = 0;
    int          max_run = 0;

    always #5 CLK = ~CLK;

    cnn_layer_accel_macc_array #(
        .NUM_LANES(4), .A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(48),
        .OUT_WIDTH(16), .FRAC_SHIFT(8), .LEN_WIDTH(10)
    ) dut (
        .CLK(CLK), .rst(rst), .cfg_len(cfg_len), .cfg_bias_en(cfg_bias_en), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_res(input logic [63:0] d, input logic [3:0] s);
        exp_q.push_back({s, d});
    endtask

    // Presents one beat and holds it until it is taken on a rising edge.
    task automatic send(input logic [63:0] a, input logic [15:0] b, input logic [9:0] len,
                        input logic ben, input logic [191:0] bv);
        bit took;
        took        = 1'b0;
        in_a        = a;
        in_b        = b;
        cfg_len     = len;
        cfg_bias_en = ben;
        bias        = bv;
        in_valid    = 1'b1;
        for (int t = 0; t < 100 && !took; t++) begin
            @(negedge CLK);
            took = in_ready;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        if (!took) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        repeat (8) step();
    endtask

    // In-order result scoreboard, sampled mid-cycle.
    always @(negedge CLK) begin
        if (rst) begin
            if (out_valid) begin
                run_len = run_len + 1;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    logic [67:0] e;
                    e = exp_q.pop_front();
                    check("res_data", out_data, e[63:0]);
                    check("res_sat", {60'd0, out_sat}, {60'd0, e[67:64]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] hold;
        bit          changed;
        logic [15:0] v;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_len = 10'd1;
        cfg_bias_en = 1'b0; bias = '0; in_a = '0; in_b = '0;
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_sat", {60'd0, out_sat}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        step();
        rst = 1'b1;
        step();

        // Basic group of 3; later beats carry different cfg that must be ignored.
        expect_res(pack4(16'd1536, 16'd0, 16'd0, 16'd0), 4'b0000);
        send(pack4(16'd256, 16'd0, 16'd0, 16'd0), 16'd256, 10'd3, 1'b0, '0);
        check("basic_busy", {63'd0, busy}, 64'd1);
        send(pack4(16'd512, 16'd0, 16'd0, 16'd0), 16'd256, 10'd1, 1'b1, {4{48'd128}});
        send(pack4(16'd768, 16'd0, 16'd0, 16'd0), 16'd256, 10'd1, 1'b1, {4{48'd128}});
        check("lat_k0", {63'd0, out_valid}, 64'd0);
        step();
        check("lat_k1", {63'd0, out_valid}, 64'd0);
        step();
        check("lat_k2", {63'd0, out_valid}, 64'd0);
        step();
        check("lat_k3", {63'd0, out_valid}, 64'd1);
        check("basic_lane0", {48'd0, out_data[15:0]}, 64'd1536);
        drain();
        check("idle_busy", {63'd0, busy}, 64'd0);

        // Bias and round-half-up, including negative halves and cfg_len = 0.
        expect_res(pack4(16'd1, 16'd0, 16'd0, 16'd0), 4'b0000);
        send(pack4(16'd2, 16'd0, 16'd0, 16'd0), 16'd3, 10'd1, 1'b1, {144'd0, 48'd128});
        expect_res(pack4(16'd0, 16'd0, 16'd0, 16'd0), 4'b0000);
        send(pack4(16'd2, 16'd0, 16'd0, 16'd0), 16'd3, 10'd1, 1'b1, {144'd0, 48'd121});
        expect_res(pack4(16'd0, 16'hFFFF, 16'd1, 16'd0), 4'b0000);
        send(pack4(16'hFFFE, 16'hFFFD, 16'd4, 16'd0), 16'd64, 10'd1, 1'b0, '0);
        expect_res(pack4(16'd512, 16'd0, 16'd0, 16'd0), 4'b0000);
        send(pack4(16'd512, 16'd0, 16'd0, 16'd0), 16'd256, 10'd0, 1'b0, '0);
        drain();

        // Saturation, then exact clamp boundaries driven through per-lane bias.
        expect_res(pack4(16'h7FFF, 16'h8000, 16'd0, 16'd0), 4'b0011);
        repeat (4) send(pack4(16'h7FFF, 16'h8000, 16'd0, 16'd0), 16'h7FFF, 10'd4, 1'b0, '0);
        expect_res(pack4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000), 4'b1100);
        send(pack4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000), 16'd256, 10'd1, 1'b1,
             {48'hFFFF_FFFF_FF7F, 48'd256, 48'd0, 48'd0});
        drain();

        // Backpressure: fill the pipe, hold five cycles, then release.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) expect_res(pack4(16'(256 * k), 16'd0, 16'd0, 16'd0), 4'b0000);
        for (int k = 1; k <= 4; k++) send(pack4(16'(256 * k), 16'd0, 16'd0, 16'd0), 16'd256, 10'd1, 1'b0, '0);
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        fork
            send(pack4(16'd1280, 16'd0, 16'd0, 16'd0), 16'd256, 10'd1, 1'b0, '0);
            begin
                hold    = out_data;
                changed = 1'b0;
                repeat (5) begin
                    step();
                    if (out_data !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) changed = 1'b1;
                end
                check("bp_stable", {63'd0, changed}, 64'd0);
                check("bp_hold_data", hold, pack4(16'd256, 16'd0, 16'd0, 16'd0));
                out_ready = 1'b1;
            end
        join
        drain();

        // Streaming: one-beat groups back to back, alternating weight sign.
        max_run = 0;
        for (int i = 0; i < 16; i++) begin
            logic [63:0] a_vec, e_vec;
            for (int l = 0; l < 4; l++) begin
                a_vec[l*16 +: 16] = 16'(i * 16 + l);
                v = (i % 2 == 1) ? 16'(-(i * 16 + l)) : 16'(i * 16 + l);
                e_vec[l*16 +: 16] = v;
            end
            expect_res(e_vec, 4'b0000);
            send(a_vec, (i % 2 == 1) ? 16'hFF00 : 16'h0100, 10'd1, 1'b0, '0);
        end
        drain();
        check("stream_run", 64'(max_run), 64'd16);

        // Reset in the middle of a group leaves no residue.
        send(pack4(16'd1000, 16'd1000, 16'd0, 16'd0), 16'd1000, 10'd3, 1'b0, '0);
        send(pack4(16'd1000, 16'd1000, 16'd0, 16'd0), 16'd1000, 10'd3, 1'b0, '0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_sat", {60'd0, out_sat}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        step();
        rst = 1'b1;
        step();
        expect_res(pack4(16'd512, 16'd0, 16'd0, 16'd0), 4'b0000);
        send(pack4(16'd256, 16'd0, 16'd0, 16'd0), 16'd256, 10'd2, 1'b0, '0);
        send(pack4(16'd256, 16'd0, 16'd0, 16'd0), 16'd256, 10'd2, 1'b0, '0);
        drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
